serial_twos_comp_stream: RTL and testbench

- Parametrised, word-framed successor to the single-bit serial two's complementer.
- Accepts WIDTH-bit words LSB-first on a serial valid/ready input.
- Per word, applies a mode: pass, negate or absolute value.
- Streams the result LSB-first on a serial valid/ready output, with word-last and overflow flags. Sits between the serial datapath front end and downstream serial arithmetic.

---
 rtl/serial_tc_pkg.sv | 32 +++
 rtl/serial_tc_bit.sv | 42 ++++
 rtl/serial_twos_comp_stream.sv | 173 +++++++++++++++++
 tb/tb_serial_twos_comp_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_tc_pkg.sv
// Shared mode codes, state encodings and helpers for the word-framed serial
// two's complementer.
package serial_tc_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_NEG  = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic {
        IN_COLLECT = 1'b0,
        IN_HOLD    = 1'b1
    } in_state_e;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_STREAM = 1'b1
    } out_state_e;

    // Whether a word's result must be negated, given its mode and sign bit.
    function automatic logic mode_negates(input logic [1:0] m, input logic msb);
        logic neg;
        case (m)
            MODE_NEG:  neg = 1'b1;
            MODE_ABS:  neg = msb;
            MODE_PASS: neg = 1'b0;
            default:   neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/serial_tc_bit.sv
// Bit-serial negation core: copies bits up to and including the first one,
// then inverts every later bit when neg is set.
module serial_tc_bit
    import serial_tc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic neg,
    input  logic b,
    output logic y
);

    logic seen_one_q;
    logic seen_one_d;

    // Clear wins so a new word starting on the last beat of the previous one
    // begins with a fresh flag.
    always_comb begin
        seen_one_d = seen_one_q;
        if (clr) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | b;
        end else begin
            seen_one_d = seen_one_q;
        end
    end

    // seen_one state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    assign y = (neg && seen_one_q) ? ~b : b;

endmodule

// File: rtl/serial_twos_comp_stream.sv
// Word-framed serial two's complementer: collects WIDTH-bit words LSB-first,
// applies pass/negate/abs per word and streams the result LSB-first.
module serial_twos_comp_stream
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       t_clk,
    input  logic       r,
    input  logic       i,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic [1:0] mode,
    output logic       y,
    output logic       y_valid,
    input  logic       y_ready,
    output logic       y_last,
    output logic       y_ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH - 1){1'b0}}};

    in_state_e        in_state_q, in_state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [WIDTH-1:0] in_sr_q, in_sr_d;
    logic [1:0]       mode_q, mode_d;

    out_state_e       out_state_q, out_state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [WIDTH-1:0] out_buf_q, out_buf_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             in_beat_s;
    logic             word_done_s;
    logic             out_beat_s;
    logic             out_last_beat_s;
    logic             xfer_s;
    logic [WIDTH-1:0] xfer_word_s;
    logic             xfer_neg_s;
    logic             cur_bit_s;
    logic             core_y_s;

    // Handshake decode and word transfer decision.
    always_comb begin
        in_beat_s       = i_valid && (in_state_q == IN_COLLECT);
        word_done_s     = in_beat_s && (in_cnt_q == LAST_IDX);
        out_beat_s      = (out_state_q == OUT_STREAM) && y_ready;
        out_last_beat_s = out_beat_s && (out_cnt_q == LAST_IDX);
        xfer_s          = (word_done_s && ((out_state_q == OUT_IDLE) || out_last_beat_s))
                       || ((in_state_q == IN_HOLD) && out_last_beat_s);
        if (in_state_q == IN_HOLD) begin
            xfer_word_s = in_sr_q;
        end else begin
            xfer_word_s = {i, in_sr_q[WIDTH-2:0]};
        end
        xfer_neg_s = mode_negates(mode_q, xfer_word_s[WIDTH-1]);
    end

    // Input side: shift register, bit counter, per-word mode and COLLECT/HOLD.
    always_comb begin
        in_state_d = in_state_q;
        in_cnt_d   = in_cnt_q;
        in_sr_d    = in_sr_q;
        mode_d     = mode_q;
        if (in_beat_s) begin
            in_sr_d[in_cnt_q] = i;
            if (in_cnt_q == {CNT_W{1'b0}}) begin
                mode_d = mode;
            end else begin
                mode_d = mode_q;
            end
            if (in_cnt_q == LAST_IDX) begin
                in_cnt_d = {CNT_W{1'b0}};
            end else begin
                in_cnt_d = in_cnt_q + CNT_W'(1);
            end
        end else begin
            in_sr_d = in_sr_q;
        end
        case (in_state_q)
            IN_COLLECT: begin
                if (word_done_s && !xfer_s) begin
                    in_state_d = IN_HOLD;
                end else begin
                    in_state_d = IN_COLLECT;
                end
            end
            IN_HOLD: begin
                if (out_last_beat_s) begin
                    in_state_d = IN_COLLECT;
                end else begin
                    in_state_d = IN_HOLD;
                end
            end
            default: in_state_d = IN_COLLECT;
        endcase
    end

    // Output side: load on transfer, otherwise advance one bit per beat.
    always_comb begin
        out_state_d = out_state_q;
        out_cnt_d   = out_cnt_q;
        out_buf_d   = out_buf_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        if (xfer_s) begin
            out_state_d = OUT_STREAM;
            out_cnt_d   = {CNT_W{1'b0}};
            out_buf_d   = xfer_word_s;
            neg_d       = xfer_neg_s;
            ovf_d       = xfer_neg_s && (xfer_word_s == MIN_WORD);
        end else if (out_beat_s) begin
            if (out_cnt_q == LAST_IDX) begin
                out_state_d = OUT_IDLE;
                out_cnt_d   = {CNT_W{1'b0}};
            end else begin
                out_state_d = OUT_STREAM;
                out_cnt_d   = out_cnt_q + CNT_W'(1);
            end
        end else begin
            out_state_d = out_state_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            in_state_q  <= IN_COLLECT;
            in_cnt_q    <= {CNT_W{1'b0}};
            in_sr_q     <= {WIDTH{1'b0}};
            mode_q      <= MODE_PASS;
            out_state_q <= OUT_IDLE;
            out_cnt_q   <= {CNT_W{1'b0}};
            out_buf_q   <= {WIDTH{1'b0}};
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            in_cnt_q    <= in_cnt_d;
            in_sr_q     <= in_sr_d;
            mode_q      <= mode_d;
            out_state_q <= out_state_d;
            out_cnt_q   <= out_cnt_d;
            out_buf_q   <= out_buf_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cur_bit_s = out_buf_q[out_cnt_q];

    serial_tc_bit u_bit (
        .clk (t_clk),
        .rst (r),
        .en  (out_beat_s),
        .clr (xfer_s),
        .neg (neg_q),
        .b   (cur_bit_s),
        .y   (core_y_s)
    );

    // Everything below is a decode of registered state, so it holds steady
    // while the output is stalled.
    assign i_ready = (in_state_q == IN_COLLECT);
    assign y_valid = (out_state_q == OUT_STREAM);
    assign y       = y_valid && core_y_s;
    assign y_last  = y_valid && (out_cnt_q == LAST_IDX);
    assign y_ovf   = y_last && ovf_q;

endmodule

// File: tb/tb_serial_twos_comp_stream.sv
// Directed bench for serial_twos_comp_stream (WIDTH=8): vector table plus
// streaming, backpressure and asynchronous-reset sequences.
module tb_serial_twos_comp_stream;

    logic       t_clk = 1'b0;
    logic       r;
    logic       i;
    logic       i_valid;
    logic       i_ready;
    logic [1:0] mode;
    logic       y;
    logic       y_valid;
    logic       y_ready;
    logic       y_last;
    logic       y_ovf;

    serial_twos_comp_stream #(.WIDTH(8)) dut (
        .t_clk   (t_clk),
        .r       (r),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .mode    (mode),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_last  (y_last),
        .y_ovf   (y_ovf)
    );

    always #5 t_clk = ~t_clk;

    typedef struct {
        logic [1:0] m;
        logic [7:0] din;
        logic [7:0] dout;
        logic       ovf;
    } vec_t;

    typedef struct packed {
        logic       ovf;
        logic [7:0] word;
    } res_t;

    vec_t vecs[9];
    res_t res_q[$];

    int   vectors_applied = 0;
    int   miscompares = 0;
    int   cap_idx = 0;
    logic [7:0] cap_word = 8'h00;
    int   run_cnt = 0;
    int   max_run = 0;
    logic iready_low = 1'b0;
    logic pre_valid = 1'b0;

    function automatic void check(input string nm, input int tag,
                                  input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, tag, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    // Called just after a posedge; drives one bit per cycle. Mode is only
    // correct on bit 0 to show mid-word mode changes are ignored.
    task automatic send_bits(input logic [1:0] m, input logic [7:0] w,
                             input int nbits, input int drop_at);
        logic [7:0] wv;
        wv = w;
        for (int k = 0; k < nbits; k++) begin
            i       = wv[k];
            i_valid = 1'b1;
            mode    = (k == 0) ? m : ~m;
            if (k == drop_at) y_ready = 1'b0;
            if (k == nbits - 1) pre_valid = y_valid;
            for (int t = 0; t < 60 && !i_ready; t++) tick();
            if (!i_ready) check("i_ready_timeout", k, 32'd0, 32'd1);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [7:0] exp_w, input logic exp_ovf, input int tag);
        res_t res;
        for (int t = 0; t < 60 && res_q.size() == 0; t++) tick();
        if (res_q.size() == 0) begin
            check("result_timeout", tag, 32'd0, 32'd1);
        end else begin
            res = res_q.pop_front();
            check("word", tag, res.word, exp_w);
            check("ovf", tag, res.ovf, exp_ovf);
        end
    endtask

    // Output monitor: reassembles accepted bits into words on the falling edge.
    initial begin
        forever begin
            @(negedge t_clk);
            if (r) begin
                cap_idx = 0;
                run_cnt = 0;
            end else begin
                run_cnt = y_valid ? run_cnt + 1 : 0;
                if (run_cnt > max_run) max_run = run_cnt;
                if (!i_ready) iready_low = 1'b1;
                if (y_valid && y_ready) begin
                    cap_word[cap_idx[2:0]] = y;
                    if (y_last) begin
                        check("last_pos", 0, cap_idx, 32'd7);
                        res_q.push_back({y_ovf, cap_word});
                        cap_idx = 0;
                    end else begin
                        check("ovf_nonlast", cap_idx, y_ovf, 32'd0);
                        cap_idx = (cap_idx + 1) % 8;
                    end
                end
            end
        end
    end

    initial begin
        r = 1'b1; i = 1'b0; i_valid = 1'b0; y_ready = 1'b1; mode = 2'd0;
        vecs[0] = '{2'd1, 8'h06, 8'hFA, 1'b0};
        vecs[1] = '{2'd2, 8'hFB, 8'h05, 1'b0};
        vecs[2] = '{2'd2, 8'h05, 8'h05, 1'b0};
        vecs[3] = '{2'd2, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{2'd1, 8'h80, 8'h80, 1'b1};
        vecs[5] = '{2'd2, 8'h80, 8'h80, 1'b1};
        vecs[6] = '{2'd0, 8'h80, 8'h80, 1'b0};
        vecs[7] = '{2'd3, 8'h5A, 8'h5A, 1'b0};
        vecs[8] = '{2'd1, 8'h01, 8'hFF, 1'b0};

        #2;
        check("rst_y_valid", 0, y_valid, 32'd0);
        check("rst_i_ready", 0, i_ready, 32'd1);
        check("rst_y", 0, y, 32'd0);
        check("rst_y_last", 0, y_last, 32'd0);
        check("rst_y_ovf", 0, y_ovf, 32'd0);
        tick();
        tick();
        r = 1'b0;

        for (int v = 0; v < 9; v++) begin
            send_bits(vecs[v].m, vecs[v].din, 8, -1);
            check("pre_valid", v, pre_valid, 32'd0);
            check("latency", v, y_valid, 32'd1);
            wait_result(vecs[v].dout, vecs[v].ovf, v);
        end

        // Three contiguous negated words.
        max_run = 0;
        iready_low = 1'b0;
        send_bits(2'd1, 8'h01, 8, -1);
        send_bits(2'd1, 8'h7F, 8, -1);
        send_bits(2'd1, 8'hC3, 8, -1);
        wait_result(8'hFF, 1'b0, 100);
        wait_result(8'h81, 1'b0, 101);
        wait_result(8'h3D, 1'b0, 102);
        check("stream_run", 0, max_run, 32'd24);
        check("stream_iready_low", 0, iready_low, 32'd0);

        // Word A stalls at its bit 2 while word B is fully collected.
        send_bits(2'd1, 8'h06, 8, -1);
        send_bits(2'd0, 8'h5A, 8, 2);
        for (int s = 0; s < 3; s++) begin
            check("hold_i_ready", s, i_ready, 32'd0);
            check("hold_y_valid", s, y_valid, 32'd1);
            check("hold_y", s, y, 32'd0);
            check("hold_y_last", s, y_last, 32'd0);
            if (s == 2) y_ready = 1'b1;
            else tick();
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("drain_i_ready", k, i_ready, 32'd0);
        end
        check("drain_y_last", 0, y_last, 32'd1);
        tick();
        check("release_i_ready", 0, i_ready, 32'd1);
        check("release_y_valid", 0, y_valid, 32'd1);
        wait_result(8'hFA, 1'b0, 200);
        wait_result(8'h5A, 1'b0, 201);

        // Asynchronous reset while a word streams and another is half in.
        send_bits(2'd1, 8'h33, 8, -1);
        send_bits(2'd1, 8'hFF, 4, -1);
        check("pre_rst_y_valid", 0, y_valid, 32'd1);
        #2;
        r = 1'b1;
        #1;
        check("arst_y_valid", 0, y_valid, 32'd0);
        check("arst_i_ready", 0, i_ready, 32'd1);
        check("arst_y", 0, y, 32'd0);
        check("arst_y_last", 0, y_last, 32'd0);
        #7;
        r = 1'b0;
        check("arst_no_result", 0, res_q.size(), 32'd0);
        send_bits(2'd1, 8'h06, 8, -1);
        check("post_rst_latency", 0, y_valid, 32'd1);
        wait_result(8'hFA, 1'b0, 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
